// File: rtl/alarm_time_keeper.sv
// Alarm time register with edge-triggered field increments and a bounded ring FSM.
// The ring FSM compares the stored alarm time against the running clock.
module alarm_time_keeper #(
    parameter int RING_SECONDS = 60,
    parameter int RESET_HOUR   = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       upsec,
    input  logic       upmin,
    input  logic       uphour,
    input  logic       tick_1hz,
    input  logic [5:0] cur_sec,
    input  logic [5:0] cur_min,
    input  logic [4:0] cur_hour,
    input  logic       alarm_en,
    input  logic       dismiss,
    output logic [5:0] al_sec,
    output logic [5:0] al_min,
    output logic [4:0] al_hour,
    output logic       ringing
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RING = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0] RING_LIMIT   = 8'(RING_SECONDS);
    localparam logic [4:0] RESET_HOUR_V = 5'(RESET_HOUR);

    function automatic logic [5:0] wrap_inc6(input logic [5:0] val, input logic [5:0] max);
        return (val == max) ? 6'd0 : val + 6'd1;
    endfunction

    function automatic logic [4:0] wrap_inc5(input logic [4:0] val, input logic [4:0] max);
        return (val == max) ? 5'd0 : val + 5'd1;
    endfunction

    logic       upsec_q_r, upmin_q_r, uphour_q_r;
    logic [5:0] al_sec_r, al_min_r;
    logic [4:0] al_hour_r;
    state_t     state_r, state_nxt_s;
    logic [7:0] count_r, count_nxt_s;
    logic       sec_inc_s, min_inc_s, hour_inc_s, any_edit_s, match_s;

    assign sec_inc_s  = upsec  & ~upsec_q_r;
    assign min_inc_s  = upmin  & ~upmin_q_r;
    assign hour_inc_s = uphour & ~uphour_q_r;
    assign any_edit_s = sec_inc_s | min_inc_s | hour_inc_s;

    // match is taken against the stored value, before any increment lands this edge
    assign match_s = alarm_en && (cur_sec == al_sec_r) && (cur_min == al_min_r)
                     && (cur_hour == al_hour_r);

    // Edge history and independent wrapping field increments (no inter-field carry)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upsec_q_r  <= 1'b0;
            upmin_q_r  <= 1'b0;
            uphour_q_r <= 1'b0;
            al_sec_r   <= 6'd0;
            al_min_r   <= 6'd0;
            al_hour_r  <= RESET_HOUR_V;
        end else begin
            upsec_q_r  <= upsec;
            upmin_q_r  <= upmin;
            uphour_q_r <= uphour;
            if (sec_inc_s)  al_sec_r  <= wrap_inc6(al_sec_r, 6'd59);
            if (min_inc_s)  al_min_r  <= wrap_inc6(al_min_r, 6'd59);
            if (hour_inc_s) al_hour_r <= wrap_inc5(al_hour_r, 5'd23);
        end
    end

    // Ring FSM state and seconds counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            count_r <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Ring FSM next state; HOLD blocks re-trigger until the matching second passes
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        case (state_r)
            IDLE: begin
                if (match_s && !any_edit_s) begin
                    state_nxt_s = RING;
                    count_nxt_s = 8'd0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RING: begin
                if (tick_1hz) begin
                    count_nxt_s = count_r + 8'd1;
                end else begin
                    count_nxt_s = count_r;
                end
                if (dismiss || !alarm_en || any_edit_s
                    || (tick_1hz && ((count_r + 8'd1) == RING_LIMIT))) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = RING;
                end
            end
            HOLD: begin
                if (!match_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                count_nxt_s = 8'd0;
            end
        endcase
    end

    assign al_sec  = al_sec_r;
    assign al_min  = al_min_r;
    assign al_hour = al_hour_r;
    assign ringing = (state_r == RING);

endmodule

// File: tb/tb_alarm_time_keeper.sv
// Directed bench for alarm_time_keeper: vector table plus hand sequences for
// wrap, timeout and asynchronous reset behaviour.
module tb_alarm_time_keeper;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       upsec = 1'b0, upmin = 1'b0, uphour = 1'b0, tick_1hz = 1'b0;
    logic [5:0] cur_sec = 6'd56, cur_min = 6'd34;
    logic [4:0] cur_hour = 5'd12;
    logic       alarm_en = 1'b0, dismiss = 1'b0;
    logic [5:0] al_sec, al_min;
    logic [4:0] al_hour;
    logic       ringing;

    int n_vec = 0;
    int n_bad = 0;

    alarm_time_keeper #(.RING_SECONDS(3), .RESET_HOUR(7)) dut (
        .clk(clk), .reset(reset), .upsec(upsec), .upmin(upmin), .uphour(uphour),
        .tick_1hz(tick_1hz), .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
        .alarm_en(alarm_en), .dismiss(dismiss), .al_sec(al_sec), .al_min(al_min),
        .al_hour(al_hour), .ringing(ringing)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       us, um, uh, tk;
        logic [5:0] cs, cm;
        logic [4:0] ch;
        logic       en, dis;
        int         cycles;
        logic [5:0] es, em;
        logic [4:0] eh;
        logic       er;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic us, logic um, logic uh, logic [5:0] cs, logic [5:0] cm,
                                logic [4:0] ch, logic en, logic dis, int cycles,
                                logic [5:0] es, logic [5:0] em, logic [4:0] eh, logic er);
        vec_t v;
        v.us = us; v.um = um; v.uh = uh; v.tk = 1'b0;
        v.cs = cs; v.cm = cm; v.ch = ch; v.en = en; v.dis = dis; v.cycles = cycles;
        v.es = es; v.em = em; v.eh = eh; v.er = er;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [5:0] es, logic [5:0] em, logic [4:0] eh, logic er);
        n_vec++;
        if (al_sec !== es || al_min !== em || al_hour !== eh || ringing !== er) begin
            n_bad++;
            $display("FAIL %s: got sec=%0d min=%0d hour=%0d ringing=%0b, want sec=%0d min=%0d hour=%0d ringing=%0b",
                     name, al_sec, al_min, al_hour, ringing, es, em, eh, er);
        end
    endtask

    task automatic tick_cycle();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    initial begin
        // Starting state: alarm 07:00:00, clock 12:34:56, disarmed
        vecs.push_back(mk(0,1,0, 56,34,12, 0,0, 10, 0,1,7,0));
        vecs.push_back(mk(0,0,0, 56,34,12, 0,0,  1, 0,1,7,0));
        vecs.push_back(mk(0,0,1, 56,34,12, 0,0,  1, 0,1,8,0));
        vecs.push_back(mk(0,0,0, 56,34,12, 0,0,  1, 0,1,8,0));
        vecs.push_back(mk(0,0,1, 56,34,12, 0,0,  3, 0,1,9,0));
        vecs.push_back(mk(0,0,0, 56,34,12, 0,0,  1, 0,1,9,0));
        vecs.push_back(mk(1,0,0, 56,34,12, 0,0,  1, 1,1,9,0));
        vecs.push_back(mk(0,0,0, 56,34,12, 0,0,  1, 1,1,9,0));
        vecs.push_back(mk(0,0,0,  1, 1, 9, 0,0,  1, 1,1,9,0));
        vecs.push_back(mk(0,0,0,  1, 1, 9, 1,0,  1, 1,1,9,1));
        vecs.push_back(mk(0,0,0,  1, 1, 9, 1,1,  1, 1,1,9,0));
        vecs.push_back(mk(0,0,0,  1, 1, 9, 1,0,  2, 1,1,9,0));
        vecs.push_back(mk(0,0,0,  2, 1, 9, 1,0,  1, 1,1,9,0));
        vecs.push_back(mk(0,0,0,  1, 1, 9, 1,0,  1, 1,1,9,1));
        vecs.push_back(mk(0,0,0,  1, 1, 9, 0,0,  1, 1,1,9,0));
        vecs.push_back(mk(0,0,0,  1, 1, 9, 0,0,  1, 1,1,9,0));
        vecs.push_back(mk(0,0,0,  1, 1, 9, 1,0,  1, 1,1,9,1));
        vecs.push_back(mk(1,1,1,  1, 1, 9, 1,0,  1, 2,2,10,0));
        vecs.push_back(mk(0,0,0,  1, 1, 9, 1,0,  1, 2,2,10,0));
        vecs.push_back(mk(0,0,0,  2, 2,10, 1,0,  1, 2,2,10,1));

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 6'd0, 6'd0, 5'd7, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            upsec = vecs[i].us; upmin = vecs[i].um; uphour = vecs[i].uh; tick_1hz = vecs[i].tk;
            cur_sec = vecs[i].cs; cur_min = vecs[i].cm; cur_hour = vecs[i].ch;
            alarm_en = vecs[i].en; dismiss = vecs[i].dis;
            repeat (vecs[i].cycles) step();
            check($sformatf("vec%0d", i), vecs[i].es, vecs[i].em, vecs[i].eh, vecs[i].er);
        end

        // Asynchronous reset while ringing at 10:02:02
        #3;
        reset = 1'b0;
        #1;
        check("async_reset", 6'd0, 6'd0, 5'd7, 1'b0);
        cur_sec = 6'd0; cur_min = 6'd0; cur_hour = 5'd7; alarm_en = 1'b1;
        #2;
        reset = 1'b1;
        step();
        check("ring_after_release", 6'd0, 6'd0, 5'd7, 1'b1);

        // Timeout after three ticks, then no re-ring within the same match
        tick_cycle(); step();
        check("tick1", 6'd0, 6'd0, 5'd7, 1'b1);
        tick_cycle(); step();
        check("tick2", 6'd0, 6'd0, 5'd7, 1'b1);
        tick_cycle();
        check("tick3_timeout", 6'd0, 6'd0, 5'd7, 1'b0);
        repeat (3) step();
        check("hold_no_retrigger", 6'd0, 6'd0, 5'd7, 1'b0);
        cur_sec = 6'd1;
        tick_cycle();
        check("cur_moved_on", 6'd0, 6'd0, 5'd7, 1'b0);
        cur_sec = 6'd0;
        step();
        check("ring_again", 6'd0, 6'd0, 5'd7, 1'b1);

        // Wrap of seconds (no carry) and hours
        alarm_en = 1'b0;
        cur_sec = 6'd56; cur_min = 6'd34; cur_hour = 5'd12;
        for (int i = 1; i <= 60; i++) begin
            upsec = 1'b1; step();
            upsec = 1'b0; step();
            if (i == 59) check("sec_59", 6'd59, 6'd0, 5'd7, 1'b0);
        end
        check("sec_wrap", 6'd0, 6'd0, 5'd7, 1'b0);
        for (int i = 1; i <= 17; i++) begin
            uphour = 1'b1; step();
            uphour = 1'b0; step();
            if (i == 16) check("hour_23", 6'd0, 6'd0, 5'd23, 1'b0);
        end
        check("hour_wrap", 6'd0, 6'd0, 5'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
